// File: rtl/skew_feeder_pkg.sv
// Shared constants and the feeder state encoding for the systolic-array edge feeders.
package skew_feeder_pkg;

  localparam int DEFAULT_ARR_SIZE = 2;
  localparam int HORIZONTAL_BW    = 16;
  localparam int VERTICAL_BW      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// DELAY-stage register chain carrying one lane of data plus its valid flag.
// DELAY=0 degenerates to a wire so lane 0 sees only the feeder's output register.
module skew_delay_line #(
  parameter int DATA_BW = 16,
  parameter int DELAY   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_BW-1:0] data_i,
  input  logic               valid_i,
  output logic [DATA_BW-1:0] data_o,
  output logic               valid_o
);

  if (DELAY == 0) begin : g_bypass
    assign data_o  = data_i;
    assign valid_o = valid_i;
  end else begin : g_chain
    logic [DATA_BW-1:0] data_q  [DELAY];
    logic               valid_q [DELAY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) begin
          data_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end
      end else begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i;
        for (int i = 1; i < DELAY; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign data_o  = data_q[DELAY-1];
    assign valid_o = valid_q[DELAY-1];
  end

endmodule

// File: rtl/skew_feeder.sv
// Vector FIFO plus a block-sequencing FSM that feeds one systolic-array edge,
// delaying lane k by k cycles so each vector enters the array as a diagonal wavefront.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int ARR_SIZE   = DEFAULT_ARR_SIZE,
  parameter int DATA_BW    = HORIZONTAL_BW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BW*ARR_SIZE-1:0] in_data,
  input  logic                        in_last,
  output logic [DATA_BW*ARR_SIZE-1:0] out_data,
  output logic [ARR_SIZE-1:0]         out_lane_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int VEC_W   = DATA_BW * ARR_SIZE;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DRAIN_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'((ARR_SIZE > 1) ? ARR_SIZE - 2 : 0);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);

  logic [VEC_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic             fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, push, pop;
  logic [VEC_W-1:0] head_data, pop_vec;
  logic             head_last;

  feeder_state_e      state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               end_evt, end_q, done_q;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_last = fifo_last_q[rd_ptr_q];

  // Storage has no reset: only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= in_data;
      fifo_last_q[wr_ptr_q] <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pop         = 1'b0;
    end_evt     = 1'b0;
    unique case (state_q)
      IDLE, STREAM: begin
        // An empty FIFO in STREAM simply issues a bubble; the block never stalls.
        if (!empty) begin
          pop     = 1'b1;
          state_d = STREAM;
          if (head_last) begin
            if (ARR_SIZE > 1) begin
              state_d     = DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end else begin
              state_d = IDLE;
              end_evt = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = IDLE;
          end_evt = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done trails the end of drain by two edges so it lands one cycle after the
  // last lane of the final vector leaves its output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      end_q       <= end_evt;
      done_q      <= end_q;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign pop_vec = pop ? head_data : '0;

  for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_lane
    logic [DATA_BW-1:0] lane_dly_data;
    logic               lane_dly_valid;
    logic [DATA_BW-1:0] lane_data_q;
    logic               lane_valid_q;

    skew_delay_line #(
      .DATA_BW (DATA_BW),
      .DELAY   (gi)
    ) u_delay (
      .clk     (clk),
      .rst     (rst),
      .data_i  (pop_vec[gi*DATA_BW +: DATA_BW]),
      .valid_i (pop),
      .data_o  (lane_dly_data),
      .valid_o (lane_dly_valid)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_data_q  <= '0;
        lane_valid_q <= 1'b0;
      end else begin
        lane_data_q  <= lane_dly_data;
        lane_valid_q <= lane_dly_valid;
      end
    end

    assign out_data[gi*DATA_BW +: DATA_BW] = lane_data_q;
    assign out_lane_valid[gi]              = lane_valid_q;
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder at ARR_SIZE=2, DATA_BW=16, FIFO_DEPTH=4: directed tables,
// hand-written corner sequences and random traffic, all against a transaction-level model.
module tb_skew_feeder;

  localparam int N     = 2;
  localparam int BW    = 16;
  localparam int DEPTH = 4;
  localparam int VW    = N * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, busy, done;
  logic [VW-1:0] in_data, out_data;
  logic [N-1:0]  out_lane_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  skew_feeder #(
    .ARR_SIZE   (N),
    .DATA_BW    (BW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .done           (done)
  );

  // Reference model: a queue of pending vectors plus a short history of what
  // was popped at each edge; lane k shows the vector popped k edges ago.
  typedef struct packed {
    logic [VW-1:0] data;
    logic          last;
  } entry_t;

  entry_t        fifo_q[$];
  logic [VW-1:0] hist_data  [N+1];
  logic          hist_valid [N+1];
  logic          hist_last  [N+1];
  int            block_left;
  bit            in_block;

  logic [VW-1:0] exp_data;
  logic [N-1:0]  exp_lv;
  logic          exp_busy, exp_done, exp_ready;

  task automatic model_edge(input logic r, input logic v, input logic [VW-1:0] d, input logic l);
    int     pre;
    bit     do_pop, do_push;
    entry_t popped;
    if (r) begin
      fifo_q.delete();
      for (int i = 0; i <= N; i++) begin
        hist_data[i]  = '0;
        hist_valid[i] = 1'b0;
        hist_last[i]  = 1'b0;
      end
      block_left = 0;
      in_block   = 0;
    end else begin
      pre     = fifo_q.size();
      do_pop  = (pre > 0) && (block_left == 0);
      do_push = v && (pre < DEPTH);
      for (int i = N; i > 0; i--) begin
        hist_data[i]  = hist_data[i-1];
        hist_valid[i] = hist_valid[i-1];
        hist_last[i]  = hist_last[i-1];
      end
      if (block_left > 0) block_left--;
      if (do_pop) begin
        popped        = fifo_q.pop_front();
        hist_data[0]  = popped.data;
        hist_valid[0] = 1'b1;
        hist_last[0]  = popped.last;
        if (popped.last) begin
          in_block   = 0;
          block_left = N - 1;
        end else begin
          in_block = 1;
        end
      end else begin
        hist_data[0]  = '0;
        hist_valid[0] = 1'b0;
        hist_last[0]  = 1'b0;
      end
      if (do_push) fifo_q.push_back('{data: d, last: l});
    end
    for (int k = 0; k < N; k++) begin
      exp_data[k*BW +: BW] = hist_data[k][k*BW +: BW];
      exp_lv[k]            = hist_valid[k];
    end
    exp_done  = hist_valid[N] && hist_last[N];
    exp_busy  = in_block || (block_left > 0);
    exp_ready = (fifo_q.size() < DEPTH);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic r, input logic v, input logic [VW-1:0] d, input logic l);
    rst      = r;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    model_edge(r, v, d, l);
    #1;
    check("out_data", {32'd0, out_data}, {32'd0, exp_data});
    check("out_lane_valid", {62'd0, out_lane_valid}, {62'd0, exp_lv});
    check("busy", {63'd0, busy}, {63'd0, exp_busy});
    check("done", {63'd0, done}, {63'd0, exp_done});
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    $display("t=%0t rst=%0b v=%0b d=%h l=%0b | out=%h lv=%b busy=%0b done=%0b rdy=%0b",
             $time, r, v, d, l, out_data, out_lane_valid, busy, done, in_ready);
  endtask

  typedef struct {
    logic          v;
    logic [VW-1:0] d;
    logic          l;
    logic [VW-1:0] e_data;
    logic [N-1:0]  e_lv;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Basic block: lane1 trails lane0 by one cycle, done one cycle after lane1=4.
    tbl[0]  = '{1'b1, 32'h0002_0001, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h0004_0003, 1'b1, 32'h0000_0001, 2'b01, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 32'h0002_0003, 2'b11, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 32'h0004_0000, 2'b10, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
    // Bubble: two empty slots between V0 and V1 on each lane.
    tbl[6]  = '{1'b1, 32'h00B0_00A0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 32'h0000_00A0, 2'b01, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 32'h00B0_0000, 2'b10, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h00D0_00C0, 1'b1, 32'h0000_0000, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0000_00C0, 2'b01, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 32'h00D0_0000, 2'b10, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("reset_out_data", {32'd0, out_data}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 14; i++) begin
      step(1'b0, tbl[i].v, tbl[i].d, tbl[i].l);
      check($sformatf("tbl%0d_data", i), {32'd0, out_data}, {32'd0, tbl[i].e_data});
      check($sformatf("tbl%0d_lv", i), {62'd0, out_lane_valid}, {62'd0, tbl[i].e_lv});
      check($sformatf("tbl%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
      check($sformatf("tbl%0d_done", i), {63'd0, done}, {63'd0, tbl[i].e_done});
    end

    // Back-to-back blocks: C arrives during DRAIN and starts only after a one-cycle idle gap.
    step(1'b0, 1'b1, 32'h1111_1010, 1'b0);
    step(1'b0, 1'b1, 32'h2222_2020, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h3333_3030, 1'b1);
    check("b2b_busy_gap", {63'd0, busy}, 64'd0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("b2b_restart_busy", {63'd0, busy}, 64'd1);
    check("b2b_done_first", {63'd0, done}, 64'd1);
    check("b2b_next_lane0", {32'd0, out_data}, 64'h0000_3030);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);

    // Full: every vector ends a block, so drain gaps let the FIFO fill.
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b1);
      if (i == 7) check("full_ready_low", {63'd0, in_ready}, 64'd0);
      if (i == 8) check("full_ready_back", {63'd0, in_ready}, 64'd1);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0);

    // Reset one cycle after the first pop of a 3-vector block.
    step(1'b0, 1'b1, 32'hAAAA_0001, 1'b0);
    step(1'b0, 1'b1, 32'hAAAA_0002, 1'b0);
    step(1'b1, 1'b1, 32'hAAAA_0003, 1'b1);
    check("rst_mid_out", {32'd0, out_data}, 64'd0);
    check("rst_mid_lv", {62'd0, out_lane_valid}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      check("rst_no_done", {63'd0, done}, 64'd0);
      check("rst_fifo_empty", {63'd0, busy}, 64'd0);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 SHALL have parameter ARR_SIZE, default 2, giving the number of lanes, one per systolic array row/column.
REQ-002 SHALL have parameter DATA_BW, default 16, giving the bits per lane (instantiated at 16 for the horizontal feed, 32 for the vertical feed).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the vector FIFO depth in entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1, in_data  input  DATA_BW*ARR_SIZE and in_last  input  1, forming the upstream vector handshake; lane k is bits [k*DATA_BW +: DATA_BW].
REQ-007 SHALL have port out_data  output  DATA_BW*ARR_SIZE  meaning the skewed vector driving the array edge input.
REQ-008 SHALL have port out_lane_valid  output  ARR_SIZE  meaning lane k of out_data carries real (non-filler) data.
REQ-009 SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-010 SHALL have port done  output  1  meaning a one-cycle pulse at the end of a block.

Function
REQ-011 A transfer SHALL occur when in_valid && in_ready; each transfer pushes {in_data, in_last} into the FIFO.
REQ-012 in_ready SHALL equal !full; a push when full never occurs, and no full-bypass is provided.
REQ-013 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-014 The FSM SHALL have states IDLE, STREAM and DRAIN.
REQ-015 IDLE->STREAM SHALL occur when the FIFO is non-empty, and the first entry is popped in that same cycle.
REQ-016 In STREAM, one entry SHALL be popped per cycle while the FIFO is non-empty; if the FIFO is empty, a zero vector with lane-valid 0 SHALL be issued (bubble) with no stall.
REQ-017 Popping an entry with last=1 SHALL move the FSM STREAM->DRAIN.
REQ-018 DRAIN SHALL issue zero vectors for ARR_SIZE-1 cycles, tracked by a drain counter.
REQ-019 After DRAIN, done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
REQ-020 For ARR_SIZE=1, DRAIN SHALL last 0 cycles and done SHALL pulse in the cycle after the last pop.
REQ-021 Pushes SHALL still be accepted during DRAIN; those entries start the next block only after returning to IDLE.
REQ-022 Skew: lane k of the vector popped at edge t SHALL appear on out_data lane k during the cycle following edge t+k, so lane 0 has 1-cycle latency and lane k has k+1.
REQ-023 out_lane_valid[k] SHALL follow the same delay as the data; bubble and drain slots SHALL show data 0 and valid 0.
REQ-024 done SHALL coincide with the cycle after lane ARR_SIZE-1 of the last vector is presented.
REQ-025 No arithmetic SHALL be performed on data; widths pass through unchanged.

Reset
REQ-026 On rst=1 at a clock edge: FIFO pointers and count SHALL clear, the state SHALL go to IDLE, the drain counter SHALL clear, and all skew registers SHALL clear.
REQ-027 Outputs during and after reset SHALL be out_data=0, out_lane_valid=0, busy=0 and done=0, with in_ready=1 the cycle after reset.
REQ-028 Reset mid-block SHALL discard all queued and in-flight data, and no done pulse SHALL follow.

Structure
REQ-029 A shared package SHALL hold the default ARR_SIZE, the HORIZONTAL_BW/VERTICAL_BW constants and the feeder state enum {IDLE, STREAM, DRAIN}.
REQ-030 There SHALL be one sub-module, skew_delay_line (parameters DATA_BW and DELAY): a DELAY-stage register chain carrying data plus valid; lane k instantiates it with DELAY=k.
REQ-031 Lane 0 SHALL use only the output register.

Verification (ARR_SIZE=2, DATA_BW=16, FIFO_DEPTH=4)
REQ-032 Scenario basic block: push {L1=0x0002,L0=0x0001} then {0x0004,0x0003,last}; required response is lane0 = 1,3 on consecutive cycles, lane1 = 2,4 one cycle later, and done high once in the cycle after lane1=4.
REQ-033 Scenario full: hold in_valid with the FSM blocked by reset release ordering, so the FIFO accepts 4 vectors; required response is in_ready=0 after the 4th push, then 1 after the first pop.
REQ-034 Scenario bubble: push V0, wait 2 cycles, then push V1 with last; required response is two zero slots with lane_valid=00 between V0 and V1 on lane 0, with lane 1 the same pattern shifted by 1.
REQ-035 Scenario back-to-back blocks: push a 2-vector block plus 1 vector of the next block during DRAIN; required response is that the next block starts only after done, with busy dropping to 0 for exactly one cycle.
REQ-036 Scenario reset mid-stream: assert rst one cycle after the first pop of a 3-vector block; required response is all outputs 0 next cycle, no done, and the FIFO empty.
